// File: rtl/bus_target.sv
// bus_target: zero-wait-state bus responder with byte-writable RAM and an MMIO page (UART TX FIFO, 64-bit cycle counter, GPIO)
// Ports: clock/reset (sync, active-high); bus_addr word address; bus_data_r combinational read data;
//        bus_data_w/bus_mask_w lane-aligned write data and byte enables; uart_tx 8N1 serial out; gpio_out GPIO register.
module bus_target #(
  parameter int RAM_WORDS    = 4096,
  parameter int CLKS_PER_BIT = 868,
  parameter int TX_DEPTH     = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] bus_addr,
  output logic [31:0] bus_data_r,
  input  logic [31:0] bus_data_w,
  input  logic [3:0]  bus_mask_w,
  output logic        uart_tx,
  output logic [31:0] gpio_out
);
  localparam int RW = $clog2(RAM_WORDS);
  localparam int PW = TX_DEPTH > 1 ? $clog2(TX_DEPTH) : 1;
  localparam int TW = $clog2(CLKS_PER_BIT);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  logic [31:0]   mem [RAM_WORDS];
  logic [7:0]    fifo_q [2**PW];
  logic [PW-1:0] wr_q, rd_q;
  logic [4:0]    level_q;
  logic [63:0]   cnt_q;
  logic [31:0]   gpio_q;
  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          sel_io, full, empty, busy, push, pop, bit_done, unused_addr;
  logic [1:0]    reg_sel;
  logic [RW-1:0] ram_idx;
  assign sel_io      = bus_addr[29];
  assign reg_sel     = bus_addr[1:0];
  assign ram_idx     = bus_addr[RW-1:0];
  assign unused_addr = ^bus_addr;
  assign full        = level_q == 5'(TX_DEPTH);
  assign empty       = level_q == 5'd0;
  assign busy        = !empty || state_q != IDLE;
  // A push into a full FIFO is dropped even when a pop frees a slot at the same edge.
  assign push        = sel_io && reg_sel == 2'd0 && bus_mask_w[0] && !full;
  assign bit_done    = timer_q == TW'(CLKS_PER_BIT - 1);
  assign uart_tx     = tx_q;
  assign gpio_out    = gpio_q;
  assign bus_data_r  = !sel_io ? mem[ram_idx] :
                       reg_sel == 2'd0 ? {23'd0, level_q, 2'b00, busy, full} :
                       reg_sel == 2'd1 ? cnt_q[31:0] :
                       reg_sel == 2'd2 ? cnt_q[63:32] : gpio_q;
  // tx_d is the line level for the next bit period, so uart_tx stays a plain register output.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q + TW'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          state_d = START;
          shift_d = fifo_q[rd_q];
          tx_d    = 1'b0;
        end
      end
      START: if (bit_done) begin
        timer_d = '0;
        idx_d   = '0;
        state_d = DATA;
        tx_d    = shift_q[0];
      end
      DATA: if (bit_done) begin
        timer_d = '0;
        idx_d   = idx_q + 3'd1;
        shift_d = shift_q >> 1;
        tx_d    = idx_q == 3'd7 ? 1'b1 : shift_q[1];
        state_d = idx_q == 3'd7 ? STOP : DATA;
      end
      STOP: if (bit_done) begin
        timer_d = '0;
        state_d = empty ? IDLE : START;
        pop     = !empty;
        shift_d = empty ? shift_q : fifo_q[rd_q];
        tx_d    = empty;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      level_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      gpio_q  <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      level_q <= level_q + 5'(push) - 5'(pop);
      wr_q    <= wr_q + PW'(push);
      rd_q    <= rd_q + PW'(pop);
      cnt_q   <= cnt_q + 64'd1;
      for (int i = 0; i < 4; i++)
        if (sel_io && reg_sel == 2'd3 && bus_mask_w[i]) gpio_q[8*i +: 8] <= bus_data_w[8*i +: 8];
    end
  end
  always_ff @(posedge clock) begin
    if (push) fifo_q[wr_q] <= bus_data_w[7:0];
    for (int i = 0; i < 4; i++)
      if (!sel_io && bus_mask_w[i]) mem[ram_idx][8*i +: 8] <= bus_data_w[8*i +: 8];
  end
endmodule

// File: tb/tb_bus_target.sv
// tb_bus_target: randomized self-checking bench for bus_target against a behavioural model
module tb_bus_target;
  localparam int RW  = 64;
  localparam int CPB = 4;
  localparam int TD  = 16;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] bus_addr = '0;
  logic [31:0] bus_data_w = '0;
  logic [3:0]  bus_mask_w = '0;
  logic [31:0] bus_data_r, gpio_out;
  logic        uart_tx;
  int          checks = 0;
  int          failures = 0;
  logic [7:0]  tx_bytes [20];
  logic [31:0] ram_m [RW];
  bit          ram_v [RW];
  logic [31:0] gpio_m;
  logic        samples [$];
  bus_target #(.RAM_WORDS(RW), .CLKS_PER_BIT(CPB), .TX_DEPTH(TD)) dut (
    .clock(clock), .reset(reset), .bus_addr(bus_addr), .bus_data_r(bus_data_r),
    .bus_data_w(bus_data_w), .bus_mask_w(bus_mask_w), .uart_tx(uart_tx), .gpio_out(gpio_out)
  );
  always #5 clock = ~clock;
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    bus_addr = a;
    bus_data_w = d;
    bus_mask_w = m;
    tick();
    bus_mask_w = '0;
  endtask
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] r = old;
    for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction
  function automatic logic exp_line(input int t, input int nb);
    int f = t / (10 * CPB);
    int p = (t % (10 * CPB)) / CPB;
    if (f >= nb || p == 9) return 1'b1;
    if (p == 0) return 1'b0;
    return tx_bytes[f][p-1];
  endfunction
  task automatic test_reset;
    reset = 1'b1;
    bus_mask_w = '0;
    tick();
    tick();
    checks += 4;
    if (uart_tx !== 1'b1) begin failures++; $display("FAIL reset_tx got %b exp 1", uart_tx); end
    if (gpio_out !== 32'd0) begin failures++; $display("FAIL reset_gpio got %h exp 0", gpio_out); end
    bus_addr = 32'h2000_0000; #1;
    if (bus_data_r !== 32'd0) begin failures++; $display("FAIL reset_status got %h exp 0", bus_data_r); end
    bus_addr = 32'h2000_0001; #1;
    if (bus_data_r !== 32'd0) begin failures++; $display("FAIL reset_counter got %h exp 0", bus_data_r); end
  endtask
  task automatic test_counter;
    int total = 0;
    reset = 1'b1;
    bus_addr = 32'h2000_0001;
    tick();
    reset = 1'b0;
    for (int it = 0; it < 4; it++) begin
      int k = it == 0 ? 100 : int'($urandom_range(1, 300));
      repeat (k) tick();
      total += k;
      bus_addr = 32'h2000_0001; #1;
      checks++;
      if (bus_data_r !== 32'(total)) begin failures++; $display("FAIL counter_lo got %0d exp %0d", bus_data_r, total); end
      bus_addr = 32'hE000_0FF2; #1;
      checks++;
      if (bus_data_r !== 32'd0) begin failures++; $display("FAIL counter_hi got %h exp 0", bus_data_r); end
    end
    wr(32'h2000_0001, 32'hFFFF_FFFF, 4'hF);
    total++;
    bus_addr = 32'h2000_0001; #1;
    checks++;
    if (bus_data_r !== 32'(total)) begin failures++; $display("FAIL counter_ro got %0d exp %0d", bus_data_r, total); end
  endtask
  task automatic test_ram;
    wr(32'd5, 32'hAABB_CCDD, 4'hF);
    wr(32'd5, 32'h0000_1100, 4'h2);
    ram_m[5] = 32'hAABB_11DD;
    ram_v[5] = 1'b1;
    bus_addr = 32'd5; #1;
    checks++;
    if (bus_data_r !== 32'hAABB_11DD) begin failures++; $display("FAIL ram_lanes got %h exp aabb11dd", bus_data_r); end
    bus_addr = 32'd5 + RW; #1;
    checks++;
    if (bus_data_r !== 32'hAABB_11DD) begin failures++; $display("FAIL ram_alias got %h exp aabb11dd", bus_data_r); end
    for (int n = 0; n < 200; n++) begin
      int idx = int'($urandom_range(0, RW - 1));
      logic [31:0] a = ($urandom & 32'hDFFF_FFC0) | 32'(idx);
      logic [31:0] d = $urandom;
      logic [3:0] m = 4'($urandom);
      if ($urandom_range(0, 1) == 0 && m != 0) begin
        wr(a, d, m);
        ram_m[idx] = merge(ram_v[idx] ? ram_m[idx] : 32'd0, d, m);
        if (!ram_v[idx] && m != 4'hF) wr(a, ram_m[idx], ~m);
        ram_v[idx] = 1'b1;
      end else if (ram_v[idx]) begin
        bus_addr = a; #1;
        checks++;
        if (bus_data_r !== ram_m[idx]) begin failures++; $display("FAIL ram_rand[%0d] got %h exp %h", idx, bus_data_r, ram_m[idx]); end
      end
    end
  endtask
  task automatic test_gpio;
    wr(32'h2000_0003, 32'h1234_5678, 4'hF);
    wr(32'h2000_0003, 32'hFF00_0000, 4'h8);
    gpio_m = 32'hFF34_5678;
    checks++;
    if (gpio_out !== gpio_m) begin failures++; $display("FAIL gpio_mask got %h exp %h", gpio_out, gpio_m); end
    for (int n = 0; n < 12; n++) begin
      logic [31:0] d = $urandom;
      logic [3:0] m = 4'($urandom);
      wr(32'h2000_0003 | ($urandom & 32'hDFFF_FFFC), d, m);
      gpio_m = merge(gpio_m, d, m);
      bus_addr = 32'hE000_0FF7; #1;
      checks++;
      if (bus_data_r !== gpio_m || gpio_out !== gpio_m) begin
        failures++; $display("FAIL gpio_rand read %h pin %h exp %h", bus_data_r, gpio_out, gpio_m);
      end
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (gpio_out !== 32'd0) begin failures++; $display("FAIL gpio_reset got %h exp 0", gpio_out); end
  endtask
  task automatic uart_burst(input int n, input string name);
    int nb = n < TD + 1 ? n : TD + 1;
    int total = nb * 10 * CPB;
    int lvl = n == 1 ? 1 : (n - 1 < TD ? n - 1 : TD);
    int bad = 0;
    samples.delete();
    bus_addr = 32'h2000_0000;
    for (int i = 0; i < n; i++) begin
      bus_data_w = {24'h0, tx_bytes[i]};
      bus_mask_w = 4'h1;
      tick();
      if (i == 0) begin
        checks++;
        if (uart_tx !== 1'b1) begin failures++; $display("FAIL %s tx_early got %b exp 1", name, uart_tx); end
      end else samples.push_back(uart_tx);
    end
    bus_mask_w = '0;
    #1;
    checks++;
    if (bus_data_r !== {23'd0, 5'(lvl), 2'b00, 1'b1, lvl == TD}) begin
      failures++; $display("FAIL %s status got %h exp level %0d full %0d", name, bus_data_r, lvl, lvl == TD);
    end
    while (samples.size() < total + 8) begin
      tick();
      samples.push_back(uart_tx);
    end
    for (int t = 0; t < total + 8; t++) begin
      checks++;
      if (samples[t] !== exp_line(t, nb)) begin
        failures++; bad++;
        if (bad < 10) $display("FAIL %s line[%0d] got %b exp %b", name, t, samples[t], exp_line(t, nb));
      end
    end
    checks++;
    if (bus_data_r !== 32'd0) begin failures++; $display("FAIL %s idle_status got %h exp 0", name, bus_data_r); end
  endtask
  task automatic test_uart_single;
    tx_bytes[0] = 8'h55;
    uart_burst(1, "uart_single");
  endtask
  task automatic test_uart_overflow;
    for (int i = 0; i < 20; i++) tx_bytes[i] = 8'(i);
    uart_burst(20, "uart_overflow");
  endtask
  task automatic test_back_to_back;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 20; i++) tx_bytes[i] = 8'($urandom);
      uart_burst(int'($urandom_range(2, 6)), "uart_b2b");
    end
  endtask
  task automatic test_mid_reset;
    int bad = 0;
    tx_bytes[0] = 8'($urandom);
    wr(32'h2000_0000, {24'h0, tx_bytes[0]}, 4'h1);
    wr(32'h2000_0000, {24'h0, 8'($urandom)}, 4'h1);
    repeat (17) tick();
    checks++;
    if (uart_tx !== tx_bytes[0][3]) begin failures++; $display("FAIL mid_bit3 got %b exp %b", uart_tx, tx_bytes[0][3]); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks += 2;
    if (uart_tx !== 1'b1) begin failures++; $display("FAIL mid_reset_tx got %b exp 1", uart_tx); end
    if (bus_data_r !== 32'd0) begin failures++; $display("FAIL mid_reset_status got %h exp 0", bus_data_r); end
    repeat (60) begin
      tick();
      if (uart_tx !== 1'b1 || bus_data_r !== 32'd0) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL mid_reset_quiet got %0d active cycles exp 0", bad); end
  endtask
  initial begin
    test_reset();
    test_counter();
    test_ram();
    test_gpio();
    test_uart_single();
    test_uart_overflow();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bus_target.md
# bus_target

Memory-side responder for the core's single-port word bus: a byte-writable RAM plus a small memory-mapped I/O page (UART transmitter with FIFO, 64-bit cycle counter, GPIO output register). It sits on the other end of the core's `bus_addr` / `bus_data_r` / `bus_data_w` / `bus_mask_w` port. It serves instruction fetch, loads and stores with zero wait states. Reads are combinational from `bus_addr`; writes commit on the clock edge.

## Interface
- `RAM_WORDS`, default 4096: RAM depth in 32-bit words; power of two.
- `CLKS_PER_BIT`, default 868: UART bit period in clocks; must be ≥ 2.
- `TX_DEPTH`, default 16: UART FIFO depth in bytes; power of two, ≤ 16.
- `clock`  in  1  clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `bus_addr`  in  32  word address (byte address / 4).
- `bus_data_r`  out  32  read data, combinational from `bus_addr`.
- `bus_data_w`  in  32  write data, already lane-shifted by the initiator.
- `bus_mask_w`  in  4  byte-lane write enables; all-zero means no write.
- `uart_tx`  out  1  serial 8N1 output, idle high.
- `gpio_out`  out  32  GPIO register value.

## Operation
- Decode uses `bus_addr[29]`:
  - 0: RAM. Index is `bus_addr[log2(RAM_WORDS)-1:0]`; higher bits are ignored (aliasing).
  - 1: MMIO. Register select is `bus_addr[1:0]`; other bits are ignored.
- RAM write: for each lane i with `bus_mask_w[i]` set, byte i is written at the edge. Other lanes are unchanged. RAM is not cleared by reset.
- MMIO 0, UART:
  - Write with `bus_mask_w[0]` set pushes `bus_data_w[7:0]`.
  - If the FIFO is full before the edge, the push is dropped. This holds even if a pop occurs at the same edge.
  - Read returns: bit0 = full; bit1 = busy (FIFO non-empty or transmitter not IDLE); bits[8:4] = FIFO level (0..TX_DEPTH); all other bits 0.
- MMIO 1: counter low 32 bits, read-only.
- MMIO 2: counter high 32 bits, read-only. Writes to 1 and 2 are ignored.
- Cycle counter: 64-bit, increments at every edge with reset low, wraps at 2^64. Reads are not snapshotted; software handles low-word carry.
- MMIO 3, GPIO: byte-masked write like RAM; read returns the current `gpio_out`.
- Transmitter FSM:
  - IDLE → START when the FIFO is non-empty. Pop the head byte into the shift register, drive `uart_tx`=0, load the bit timer.
  - START → DATA after CLKS_PER_BIT cycles.
  - DATA sends 8 bits, LSB first, each held CLKS_PER_BIT cycles → STOP.
  - STOP drives 1 for CLKS_PER_BIT cycles. Then, if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- `uart_tx` is a register output, glitch-free.
- Reset: `uart_tx`=1, `gpio_out`=0, counter=0, FIFO empty (level 0), FSM IDLE, bit timer and bit index 0. Reset mid-frame aborts the frame and discards queued bytes; the line returns high at the next edge.

## Timing
- Read latency is 0 cycles: `bus_data_r` reflects `bus_addr` and current state in the same cycle. A read in the cycle after a write to the same address returns the new data.
- Write commits at the edge ending the cycle in which `bus_mask_w` is non-zero. There is no handshake; each cycle with a non-zero mask is one write. A multi-cycle hold writes repeatedly, and for UART pushes repeatedly.
- UART latency: push at edge N (FIFO previously empty, FSM IDLE) → `uart_tx` falls at edge N+1.
- A frame is exactly 10·CLKS_PER_BIT cycles. Back-to-back frames have no gap.
- Full/level read in the cycle after a push includes that push.
- Simultaneous push and pop with FIFO neither empty nor full: level unchanged, both take effect.

## Test plan
- RAM byte lanes: write 0xAABBCCDD mask 1111 at word 5, then 0x00001100 mask 0010 → read word 5 = 0xAABB11DD. Word 5+RAM_WORDS reads the same value.
- Counter: after reset release, hold `bus_addr`=0x20000001; the read value equals the number of elapsed edges (e.g. 100 after 100 edges). With high word preset by forcing, the low-word wrap carries into `bus_addr`=0x20000002.
- UART single frame, CLKS_PER_BIT=4: push 0x55. `uart_tx` falls the next edge and shows 0,1,0,1,0,1,0,1,0,1, each held 4 cycles, then stays high. Status bit1 goes back to 0 after 40 cycles.
- UART overflow, TX_DEPTH=16: 20 consecutive pushes 0x00..0x13 with the transmitter busy → level reads 16, full=1. Exactly bytes 0x00..0x10 appear on the line, back-to-back with no gaps.
- GPIO: write 0x12345678 mask 1111, then 0xFF000000 mask 1000 → `gpio_out`=0xFF345678. Reset → 0.
- Reset mid-frame during DATA bit 3 → `uart_tx`=1 at the next edge, status reads 0, and no further frame is sent.
